// File: rtl/deparser_pkg.sv
// Shared types, bus widths and header-selection helpers for the deparser.
// Optional payload copy is enabled by defining DEPARSER_PAYLOAD_EN.
package deparser_pkg;

    localparam int ADDR_BUS     = 32;
    localparam int DATA_BUS     = 32;
    localparam int WORD_WIDTH   = 32;
    localparam int NUM_HEADERS  = 2;
    localparam int DEF_HDR0_LEN = 14;
    localparam int DEF_HDR1_LEN = 20;
    localparam int DP_STATE_BUS = 2;

    localparam logic [WORD_WIDTH-1:0] NO_HEADER = '1;

    typedef enum logic [DP_STATE_BUS-1:0] {
        DP_STATE_FREE  = 2'd0,
        DP_STATE_READ  = 2'd1,
        DP_STATE_WRITE = 2'd2,
        DP_STATE_DONE  = 2'd3
    } dp_state_t;

    // Segment being copied: one of the headers, the trailing payload, or nothing.
    typedef logic [1:0] seg_id_t;
    localparam seg_id_t SEG_HDR0    = 2'd0;
    localparam seg_id_t SEG_HDR1    = 2'd1;
    localparam seg_id_t SEG_PAYLOAD = 2'd2;
    localparam seg_id_t SEG_NONE    = 2'd3;

    typedef logic [WORD_WIDTH*NUM_HEADERS-1:0] hdr_vec_t;

    // Header 0 occupies the most significant word of the packed vector.
    function automatic logic [WORD_WIDTH-1:0] hdr_addr(input hdr_vec_t hdrs, input seg_id_t id);
        hdr_addr = '0;
        for (int i = 0; i < NUM_HEADERS; i++) begin
            if (seg_id_t'(i) == id) hdr_addr = hdrs[(NUM_HEADERS-1-i)*WORD_WIDTH +: WORD_WIDTH];
        end
    endfunction

    function automatic seg_id_t next_hdr(input hdr_vec_t hdrs, input seg_id_t from);
        next_hdr = SEG_NONE;
        for (int i = NUM_HEADERS-1; i >= 0; i--) begin
            if (i >= int'(from) && hdrs[(NUM_HEADERS-1-i)*WORD_WIDTH +: WORD_WIDTH] != NO_HEADER)
                next_hdr = seg_id_t'(i);
        end
    endfunction

    function automatic logic [3:0] chunk_width(input logic [DATA_BUS-1:0] rem);
        return (rem >= DATA_BUS'(4)) ? 4'd4 : rem[3:0];
    endfunction

endpackage

// File: rtl/deparser_if.sv
// Request/response and memory-master signals of the deparser.
// payload_len_i exists only when DEPARSER_PAYLOAD_EN is defined.
interface deparser_if;
    import deparser_pkg::*;

    logic                              start_i;
    logic [WORD_WIDTH*NUM_HEADERS-1:0] parsed_hdrs_i;
    logic [ADDR_BUS-1:0]               out_addr_i;
`ifdef DEPARSER_PAYLOAD_EN
    logic [DATA_BUS-1:0]               payload_len_i;
`endif
    logic                              mem_ce_o;
    logic                              mem_we_o;
    logic [ADDR_BUS-1:0]               mem_addr_o;
    logic [3:0]                        mem_width_o;
    logic [DATA_BUS-1:0]               mem_data_o;
    logic [DATA_BUS-1:0]               mem_data_i;
    logic                              ready_o;
    logic [DATA_BUS-1:0]               deparsed_len_o;

    modport slave (
        input  start_i, parsed_hdrs_i, out_addr_i, mem_data_i,
`ifdef DEPARSER_PAYLOAD_EN
        input  payload_len_i,
`endif
        output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        output ready_o, deparsed_len_o
    );

    modport master (
        output start_i, parsed_hdrs_i, out_addr_i, mem_data_i,
`ifdef DEPARSER_PAYLOAD_EN
        output payload_len_i,
`endif
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        input  ready_o, deparsed_len_o
    );

endinterface

// File: rtl/deparser.sv
// Re-emits valid headers (and, with DEPARSER_PAYLOAD_EN, the payload) as a
// contiguous byte stream using read/write chunk pairs of up to 4 bytes.
//
// state          | meaning
// DP_STATE_FREE  | idle, waiting for start_i
// DP_STATE_READ  | source read of the current chunk presented
// DP_STATE_WRITE | destination write of the current chunk presented
// DP_STATE_DONE  | copy finished, waiting for start_i to drop
module deparser
    import deparser_pkg::*;
#(
    parameter int HDR0_LEN = DEF_HDR0_LEN,
    parameter int HDR1_LEN = DEF_HDR1_LEN
) (
    input logic       clk,
    input logic       rst,
    deparser_if.slave bus
);

    dp_state_t           state;
    hdr_vec_t            hdrs;
    seg_id_t             seg_id;
    logic [ADDR_BUS-1:0] seg_base;
    logic [DATA_BUS-1:0] seg_len;
    logic [DATA_BUS-1:0] seg_off;
    logic [ADDR_BUS-1:0] dst_ptr;
`ifdef DEPARSER_PAYLOAD_EN
    logic [DATA_BUS-1:0] payload_len;
`endif

    logic                nxt_valid;
    seg_id_t             nxt_id;
    logic [ADDR_BUS-1:0] nxt_base;
    logic [DATA_BUS-1:0] nxt_len;
    logic [DATA_BUS-1:0] nxt_off;
    logic [3:0]          nxt_width;
    logic [DATA_BUS-1:0] adv_off;

    function automatic logic [DATA_BUS-1:0] hdr_len(input seg_id_t id);
        return (id == SEG_HDR0) ? DATA_BUS'(HDR0_LEN) : DATA_BUS'(HDR1_LEN);
    endfunction

    // Next chunk to read: first header at start, otherwise continue the
    // current segment or move on to the following one.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_id    = SEG_NONE;
        nxt_base  = '0;
        nxt_len   = '0;
        nxt_off   = '0;
        adv_off   = seg_off + DATA_BUS'(bus.mem_width_o);
        if (state == DP_STATE_FREE) begin
            nxt_id = next_hdr(bus.parsed_hdrs_i, SEG_HDR0);
            if (nxt_id != SEG_NONE) begin
                nxt_valid = 1'b1;
                nxt_base  = hdr_addr(bus.parsed_hdrs_i, nxt_id);
                nxt_len   = hdr_len(nxt_id);
            end
        end else if (adv_off < seg_len) begin
            nxt_valid = 1'b1;
            nxt_id    = seg_id;
            nxt_base  = seg_base;
            nxt_len   = seg_len;
            nxt_off   = adv_off;
        end else begin
            nxt_id = (seg_id == SEG_HDR0) ? next_hdr(hdrs, SEG_HDR1) : SEG_NONE;
            if (nxt_id != SEG_NONE) begin
                nxt_valid = 1'b1;
                nxt_base  = hdr_addr(hdrs, nxt_id);
                nxt_len   = hdr_len(nxt_id);
            end
`ifdef DEPARSER_PAYLOAD_EN
            // Payload directly follows the last header that was copied.
            else if (seg_id != SEG_PAYLOAD && payload_len != '0) begin
                nxt_valid = 1'b1;
                nxt_id    = SEG_PAYLOAD;
                nxt_base  = seg_base + ADDR_BUS'(seg_len);
                nxt_len   = payload_len;
            end
`endif
        end
        nxt_width = chunk_width(nxt_len - nxt_off);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= DP_STATE_FREE;
            hdrs               <= '0;
            seg_id             <= SEG_NONE;
            seg_base           <= '0;
            seg_len            <= '0;
            seg_off            <= '0;
            dst_ptr            <= '0;
`ifdef DEPARSER_PAYLOAD_EN
            payload_len        <= '0;
`endif
            bus.mem_ce_o       <= 1'b0;
            bus.mem_we_o       <= 1'b0;
            bus.mem_addr_o     <= '0;
            bus.mem_width_o    <= '0;
            bus.mem_data_o     <= '0;
            bus.ready_o        <= 1'b0;
            bus.deparsed_len_o <= '0;
        end else begin
            case (state)
                DP_STATE_FREE: begin
                    if (bus.start_i) begin
                        hdrs               <= bus.parsed_hdrs_i;
                        dst_ptr            <= bus.out_addr_i;
`ifdef DEPARSER_PAYLOAD_EN
                        payload_len        <= bus.payload_len_i;
`endif
                        bus.ready_o        <= 1'b0;
                        bus.deparsed_len_o <= '0;
                        if (nxt_valid) begin
                            seg_id          <= nxt_id;
                            seg_base        <= nxt_base;
                            seg_len         <= nxt_len;
                            seg_off         <= nxt_off;
                            bus.mem_ce_o    <= 1'b1;
                            bus.mem_we_o    <= 1'b0;
                            bus.mem_addr_o  <= nxt_base;
                            bus.mem_width_o <= nxt_width;
                            state           <= DP_STATE_READ;
                        end else begin
                            bus.ready_o <= 1'b1;
                            state       <= DP_STATE_DONE;
                        end
                    end
                end
                DP_STATE_READ: begin
                    bus.mem_data_o <= bus.mem_data_i;
                    bus.mem_we_o   <= 1'b1;
                    bus.mem_addr_o <= dst_ptr;
                    state          <= DP_STATE_WRITE;
                end
                DP_STATE_WRITE: begin
                    dst_ptr            <= dst_ptr + ADDR_BUS'(bus.mem_width_o);
                    bus.deparsed_len_o <= bus.deparsed_len_o + DATA_BUS'(bus.mem_width_o);
                    if (nxt_valid) begin
                        seg_id          <= nxt_id;
                        seg_base        <= nxt_base;
                        seg_len         <= nxt_len;
                        seg_off         <= nxt_off;
                        bus.mem_we_o    <= 1'b0;
                        bus.mem_addr_o  <= nxt_base + ADDR_BUS'(nxt_off);
                        bus.mem_width_o <= nxt_width;
                        state           <= DP_STATE_READ;
                    end else begin
                        bus.mem_ce_o <= 1'b0;
                        bus.mem_we_o <= 1'b0;
                        bus.ready_o  <= 1'b1;
                        state        <= DP_STATE_DONE;
                    end
                end
                DP_STATE_DONE: begin
                    if (!bus.start_i) state <= DP_STATE_FREE;
                end
                default: state <= DP_STATE_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_deparser.sv
// Self-checking bench for deparser: a byte-level memory plus a chunk-list
// model of the expected reads, writes, latency and final destination image.
module tb_deparser;
    import deparser_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  width;
        logic [31:0] data;
        int          rel;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   e0  = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   wr_seen = 0;
    logic [31:0] last_wr_addr;
    logic [3:0]  last_wr_width;
    logic [7:0]  mem [0:4095];
    acc_t exp_rd[$];
    acc_t exp_wr[$];
    logic [31:0] exp_src[$];
    logic [31:0] exp_dst[$];

    deparser_if bus ();
    deparser dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wire [11:0] rd_a = bus.mem_addr_o[11:0];
    assign bus.mem_data_i = {mem[rd_a + 12'd3], mem[rd_a + 12'd2], mem[rd_a + 12'd1], mem[rd_a]};

    always @(posedge clk) begin
        if (bus.mem_ce_o && bus.mem_we_o)
            for (int i = 0; i < int'(bus.mem_width_o); i++)
                mem[rd_a + 12'(i)] = bus.mem_data_o[8*i +: 8];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [11:0] b = a[11:0];
        return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
    endfunction

    // Every read and write the DUT presents is matched against the model.
    always @(negedge clk) begin
        if (!rst && bus.mem_ce_o) begin
            acc_t e;
            if (!bus.mem_we_o) begin
                if (exp_rd.size() == 0) chk("rd_queue_len", exp_rd.size(), 1);
                else begin
                    e = exp_rd.pop_front();
                    chk("rd_addr", bus.mem_addr_o, e.addr);
                    chk("rd_width", 32'(bus.mem_width_o), 32'(e.width));
                    chk("rd_cycle", cyc - e0, e.rel);
                end
            end else begin
                if (exp_wr.size() == 0) chk("wr_queue_len", exp_wr.size(), 1);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", bus.mem_addr_o, e.addr);
                    chk("wr_width", 32'(bus.mem_width_o), 32'(e.width));
                    chk("wr_data", bus.mem_data_o, e.data);
                    chk("wr_cycle", cyc - e0, e.rel);
                end
                wr_seen++;
                last_wr_addr  = bus.mem_addr_o;
                last_wr_width = bus.mem_width_o;
            end
        end
        if (!rst && bus.ready_o) chk("ce_when_ready", 32'(bus.mem_ce_o), 0);
    end

    task automatic build_model(input logic [31:0] h0, h1, dst, input int plen,
                               output int nchunk, output int total);
        logic [31:0] bases[$];
        int          lens[$];
        logic [31:0] last_end = 0;
        logic [31:0] d = dst;
        if (h0 != NO_HEADER) begin bases.push_back(h0); lens.push_back(14); last_end = h0 + 14; end
        if (h1 != NO_HEADER) begin bases.push_back(h1); lens.push_back(20); last_end = h1 + 20; end
        if (bases.size() > 0 && plen > 0) begin bases.push_back(last_end); lens.push_back(plen); end
        nchunk = 0;
        total  = 0;
        exp_src.delete();
        exp_dst.delete();
        foreach (bases[s]) begin
            for (int off = 0; off < lens[s]; off += 4) begin
                int w = (lens[s] - off > 4) ? 4 : lens[s] - off;
                logic [31:0] src = bases[s] + off;
                exp_rd.push_back('{src, 4'(w), 32'h0, 2*nchunk});
                exp_wr.push_back('{d, 4'(w), word_at(src), 2*nchunk + 1});
                for (int b = 0; b < w; b++) begin
                    exp_src.push_back(src + b);
                    exp_dst.push_back(d + b);
                end
                d += w;
                total += w;
                nchunk++;
            end
        end
    endtask

    task automatic launch(input logic [31:0] h0, h1, dst, input int plen);
        for (int i = 0; i < 64; i++) mem[12'(dst + i)] = 8'hEE;
        @(negedge clk);
        bus.parsed_hdrs_i = {h0, h1};
        bus.out_addr_i    = dst;
`ifdef DEPARSER_PAYLOAD_EN
        bus.payload_len_i = plen;
`endif
        bus.start_i = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic run_op(input logic [31:0] h0, h1, dst, input int plen,
                          input int lit_rdy, input int lit_len, input int lit_last_addr,
                          input int lit_last_w, input int hold);
        int n_chunk, total, lat, bad;
        build_model(h0, h1, dst, plen, n_chunk, total);
        last_wr_addr = '0;
        last_wr_width = '0;
        launch(h0, h1, dst, plen);
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.ready_o) begin lat = cyc - e0; break; end
        end
        chk("ready_seen", 32'(bus.ready_o), 1);
        chk("ready_latency", lat, 2 * n_chunk);
        chk("ready_latency_lit", lat, lit_rdy);
        chk("len", bus.deparsed_len_o, total);
        chk("len_lit", bus.deparsed_len_o, lit_len);
        if (lit_last_addr >= 0) begin
            chk("last_wr_addr_lit", last_wr_addr, lit_last_addr);
            chk("last_wr_width_lit", 32'(last_wr_width), lit_last_w);
        end
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        bad = 0;
        foreach (exp_dst[i]) if (mem[exp_dst[i][11:0]] !== mem[exp_src[i][11:0]]) bad++;
        chk("dst_image", bad, 0);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk("hold_ready", 32'(bus.ready_o), 1);
            chk("hold_len", bus.deparsed_len_o, total);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_drop", 32'(bus.ready_o), 1);
    endtask

    initial begin
        int n_chunk, total, wr_base;
        for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
        bus.start_i = 1'b0;
        bus.parsed_hdrs_i = '0;
        bus.out_addr_i = '0;
`ifdef DEPARSER_PAYLOAD_EN
        bus.payload_len_i = '0;
`endif
        #1;
        chk("rst_ce", 32'(bus.mem_ce_o), 0);
        chk("rst_we", 32'(bus.mem_we_o), 0);
        chk("rst_addr", bus.mem_addr_o, 0);
        chk("rst_width", 32'(bus.mem_width_o), 0);
        chk("rst_data", bus.mem_data_o, 0);
        chk("rst_ready", 32'(bus.ready_o), 0);
        chk("rst_len", bus.deparsed_len_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op(32'h100, 32'h10E, 32'h400, 0, 18, 34, 32'h41E, 4, 10);
        run_op(32'h100, 32'h10E, 32'h800, 0, 18, 34, 32'h81E, 4, 0);
        run_op(32'h100, NO_HEADER, 32'h400, 0, 8, 14, 32'h40C, 2, 0);
        run_op(NO_HEADER, 32'h200, 32'h600, 0, 10, 20, 32'h610, 4, 0);
        run_op(32'h133, NO_HEADER, 32'h501, 0, 8, 14, 32'h50D, 2, 0);
        run_op(NO_HEADER, NO_HEADER, 32'h400, 0, 0, 0, -1, 0, 3);

        // Abort during the third write.
        build_model(32'h100, 32'h10E, 32'h400, 0, n_chunk, total);
        wr_base = wr_seen;
        launch(32'h100, 32'h10E, 32'h400, 0);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #2;
            if (wr_seen == wr_base + 3) break;
        end
        chk("abort_reached_wr3", wr_seen - wr_base, 3);
        rst = 1'b1;
        #1;
        chk("abort_ce", 32'(bus.mem_ce_o), 0);
        chk("abort_we", 32'(bus.mem_we_o), 0);
        chk("abort_addr", bus.mem_addr_o, 0);
        chk("abort_width", 32'(bus.mem_width_o), 0);
        chk("abort_data", bus.mem_data_o, 0);
        chk("abort_ready", 32'(bus.ready_o), 0);
        chk("abort_len", bus.deparsed_len_o, 0);
        exp_rd.delete();
        exp_wr.delete();
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_abort_ready", 32'(bus.ready_o), 0);
        chk("post_abort_ce", 32'(bus.mem_ce_o), 0);
        chk("abort_no_wr3", 32'(mem[12'h408]), 32'hEE);
        chk("abort_wr2_done", 32'(mem[12'h404]), 32'(mem[12'h104]));
        run_op(32'h100, NO_HEADER, 32'h400, 0, 8, 14, 32'h40C, 2, 0);

`ifdef DEPARSER_PAYLOAD_EN
        run_op(32'h100, 32'h10E, 32'h400, 6, 22, 40, 32'h426, 2, 0);
        run_op(32'h100, NO_HEADER, 32'h400, 3, 10, 17, 32'h40E, 3, 0);
        run_op(32'h100, 32'h10E, 32'h400, 0, 18, 34, 32'h41E, 4, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
